// File: rtl/frame_fifo_read_mc_if.sv
// Burst-read port between the frame reader and the external memory controller.
// The reader owns the request, length and address; the controller returns the data strobe and completion.
interface frame_fifo_read_mc_if #(
  parameter int unsigned ADDR_BITS  = 23,
  parameter int unsigned BURST_BITS = 10
);
  logic                  rd_burst_req;
  logic [BURST_BITS-1:0] rd_burst_len;
  logic [ADDR_BITS-1:0]  rd_burst_addr;
  logic                  rd_burst_data_valid;
  logic                  rd_burst_finish;

  modport master (
    output rd_burst_req,
    output rd_burst_len,
    output rd_burst_addr,
    input  rd_burst_data_valid,
    input  rd_burst_finish
  );

  modport slave (
    input  rd_burst_req,
    input  rd_burst_len,
    input  rd_burst_addr,
    output rd_burst_data_valid,
    output rd_burst_finish
  );
endinterface

// File: rtl/frame_fifo_read_mc.sv
// Frame reader: picks one of NUM_BUF frame buffers and streams read_len words from it in bursts,
// trimming the last burst to the remainder and pacing bursts on downstream FIFO headroom.
module frame_fifo_read_mc #(
  parameter int unsigned MEM_DATA_BITS = 32,
  parameter int unsigned ADDR_BITS     = 23,
  parameter int unsigned BURST_BITS    = 10,
  parameter int unsigned NUM_BUF       = 4,
  parameter int unsigned IDX_BITS      = 2,
  parameter int unsigned FIFO_DEPTH    = 512,
  parameter int unsigned BURST_SIZE    = 128
) (
  input  logic                         mem_clk,
  input  logic                         rst,
  frame_fifo_read_mc_if.master         mem_if,
  input  logic                         i_read_req,
  output logic                         o_read_req_ack,
  output logic                         o_read_finish,
  output logic                         o_busy,
  input  logic [NUM_BUF*ADDR_BITS-1:0] i_read_addr_bus,
  input  logic [IDX_BITS-1:0]          i_read_addr_index,
  input  logic [ADDR_BITS-1:0]         i_read_len,
  output logic                         o_fifo_aclr,
  input  logic [15:0]                  i_wrusedw
);

  localparam int unsigned FIFO_THRESH = FIFO_DEPTH - BURST_SIZE;

  if (NUM_BUF < 2 || NUM_BUF > (1 << IDX_BITS) || BURST_SIZE < 1 ||
      BURST_SIZE >= (1 << BURST_BITS) || BURST_SIZE > FIFO_DEPTH || MEM_DATA_BITS == 0) begin : g_bad_params
    $error("frame_fifo_read_mc: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_CHECK_FIFO,
    S_READ_BURST,
    S_READ_BURST_END,
    S_END
  } state_t;

  state_t                r_state;
  logic [2:0]            r_req_sync;
  logic [ADDR_BITS-1:0]  r_len_s1;
  logic [ADDR_BITS-1:0]  r_len_s2;
  logic [IDX_BITS-1:0]   r_idx_s1;
  logic [IDX_BITS-1:0]   r_idx_s2;
  logic [ADDR_BITS-1:0]  r_len_latch;
  logic [ADDR_BITS-1:0]  r_read_cnt;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [BURST_BITS-1:0] r_burst_len;
  logic                  r_burst_req;
  logic                  r_ack;
  logic                  r_aclr;
  logic                  r_read_finish;
  logic                  r_busy;

  logic                  w_req_s;
  logic [ADDR_BITS-1:0]  w_base_addr;
  logic [ADDR_BITS-1:0]  w_remain;
  logic [BURST_BITS-1:0] w_burst_len;
  logic                  w_fifo_room;

  assign w_req_s     = r_req_sync[2];
  assign w_remain    = r_len_latch - r_read_cnt;
  assign w_burst_len = (w_remain > ADDR_BITS'(BURST_SIZE)) ? BURST_BITS'(BURST_SIZE)
                                                           : BURST_BITS'(w_remain);
  assign w_fifo_room = 32'(i_wrusedw) < FIFO_THRESH;

  // Out-of-range buffer indices fall back to buffer 0.
  always_comb begin
    w_base_addr = i_read_addr_bus[ADDR_BITS-1:0];
    for (int unsigned k = 1; k < NUM_BUF; k++) begin
      if (32'(r_idx_s2) == k) w_base_addr = i_read_addr_bus[k*ADDR_BITS +: ADDR_BITS];
    end
  end

  // Request crosses on three flops; length and index are quasi-static and use two.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_req_sync <= '0;
      r_len_s1   <= '0;
      r_len_s2   <= '0;
      r_idx_s1   <= '0;
      r_idx_s2   <= '0;
    end else begin
      r_req_sync <= {r_req_sync[1:0], i_read_req};
      r_len_s1   <= i_read_len;
      r_len_s2   <= r_len_s1;
      r_idx_s1   <= i_read_addr_index;
      r_idx_s2   <= r_idx_s1;
    end
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_len_latch   <= '0;
      r_read_cnt    <= '0;
      r_addr        <= '0;
      r_burst_len   <= '0;
      r_burst_req   <= 1'b0;
      r_ack         <= 1'b0;
      r_aclr        <= 1'b0;
      r_read_finish <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_read_finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          if (w_req_s) begin
            r_state <= S_ACK;
            r_busy  <= 1'b1;
          end
        end
        S_ACK: begin
          if (w_req_s) begin
            r_ack       <= 1'b1;
            r_aclr      <= 1'b1;
            r_addr      <= w_base_addr;
            r_len_latch <= r_len_s2;
            r_read_cnt  <= '0;
          end else begin
            r_ack   <= 1'b0;
            r_aclr  <= 1'b0;
            r_state <= (r_len_latch == '0) ? S_END : S_CHECK_FIFO;
          end
        end
        S_CHECK_FIFO: begin
          if (w_req_s) begin
            r_state <= S_ACK;
          end else if (w_fifo_room) begin
            r_burst_len <= w_burst_len;
            r_burst_req <= 1'b1;
            r_state     <= S_READ_BURST;
          end
        end
        // A started burst always runs to completion, even if a new frame is requested.
        S_READ_BURST: begin
          if (mem_if.rd_burst_data_valid || mem_if.rd_burst_finish) r_burst_req <= 1'b0;
          if (mem_if.rd_burst_finish) begin
            r_read_cnt <= r_read_cnt + ADDR_BITS'(r_burst_len);
            r_addr     <= r_addr + ADDR_BITS'(r_burst_len);
            r_state    <= S_READ_BURST_END;
          end
        end
        S_READ_BURST_END: begin
          if (w_req_s)                      r_state <= S_ACK;
          else if (r_read_cnt < r_len_latch) r_state <= S_CHECK_FIFO;
          else                               r_state <= S_END;
        end
        S_END: begin
          r_read_finish <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_burst_req <= 1'b0;
          r_ack       <= 1'b0;
          r_aclr      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_if.rd_burst_req  = r_burst_req;
  assign mem_if.rd_burst_len  = r_burst_len;
  assign mem_if.rd_burst_addr = r_addr;
  assign o_read_req_ack       = r_ack;
  assign o_read_finish        = r_read_finish;
  assign o_busy               = r_busy;
  assign o_fifo_aclr          = r_aclr;

endmodule

// File: tb/tb_frame_fifo_read_mc.sv
// Bench for frame_fifo_read_mc: frame-level burst model, a simple memory controller responder
// and a per-cycle monitor, plus directed frames with literal burst expectations.
module tb_frame_fifo_read_mc;
  localparam int unsigned AB = 23;
  localparam int unsigned BB = 10;
  localparam int unsigned NB = 3;
  localparam int unsigned IB = 2;
  localparam int unsigned FD = 512;
  localparam int unsigned BS = 128;
  localparam logic [AB-1:0] BASE0 = 23'h000200;
  localparam logic [AB-1:0] BASE1 = 23'h001000;
  localparam logic [AB-1:0] BASE2 = 23'h7FFFC0;

  logic             mem_clk = 1'b0;
  logic             rst;
  logic             read_req;
  logic             read_req_ack;
  logic             read_finish;
  logic             busy;
  logic [NB*AB-1:0] read_addr_bus;
  logic [IB-1:0]    read_addr_index;
  logic [AB-1:0]    read_len;
  logic             fifo_aclr;
  logic [15:0]      wrusedw;

  frame_fifo_read_mc_if #(.ADDR_BITS(AB), .BURST_BITS(BB)) mc ();

  frame_fifo_read_mc #(
    .MEM_DATA_BITS(32), .ADDR_BITS(AB), .BURST_BITS(BB), .NUM_BUF(NB),
    .IDX_BITS(IB), .FIFO_DEPTH(FD), .BURST_SIZE(BS)
  ) dut (
    .mem_clk          (mem_clk),
    .rst              (rst),
    .mem_if           (mc.master),
    .i_read_req       (read_req),
    .o_read_req_ack   (read_req_ack),
    .o_read_finish    (read_finish),
    .o_busy           (busy),
    .i_read_addr_bus  (read_addr_bus),
    .i_read_addr_index(read_addr_index),
    .i_read_len       (read_len),
    .o_fifo_aclr      (fifo_aclr),
    .i_wrusedw        (wrusedw)
  );

  always #5 mem_clk = ~mem_clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame model: a frame is a list of bursts of at most BS words walking up from its base.
  logic [AB-1:0] exp_addr_q[$];
  int            exp_len_q[$];
  logic [AB-1:0] obs_addr[$];
  int            obs_len[$];
  bit            frame_active = 1'b0;
  int            finish_cnt   = 0;
  int            aclr_rises   = 0;
  int            n_req        = 0;

  function automatic logic [AB-1:0] base_of(input int idx);
    case (idx)
      1:       return BASE1;
      2:       return BASE2;
      default: return BASE0;
    endcase
  endfunction

  task automatic model_load(input int idx, input int len);
    logic [AB-1:0] a;
    int rem;
    a   = base_of(idx);
    rem = len;
    exp_addr_q.delete();
    exp_len_q.delete();
    while (rem > 0) begin
      int b;
      b = (rem > int'(BS)) ? int'(BS) : rem;
      exp_addr_q.push_back(a);
      exp_len_q.push_back(b);
      a   = a + AB'(b);
      rem = rem - b;
    end
    frame_active = 1'b1;
  endtask

  // Memory controller responder: two idle cycles, one data strobe per word, then finish.
  int ctl_wait, ctl_left;
  bit ctl_busy;
  initial begin
    mc.rd_burst_data_valid = 1'b0;
    mc.rd_burst_finish     = 1'b0;
    ctl_busy = 1'b0; ctl_wait = 0; ctl_left = 0;
    forever begin
      @(negedge mem_clk);
      mc.rd_burst_data_valid = 1'b0;
      mc.rd_burst_finish     = 1'b0;
      if (rst) ctl_busy = 1'b0;
      else if (!ctl_busy) begin
        if (mc.rd_burst_req) begin
          ctl_busy = 1'b1; ctl_wait = 2; ctl_left = int'(mc.rd_burst_len);
        end
      end else if (ctl_wait > 0) ctl_wait--;
      else if (ctl_left > 0) begin
        mc.rd_burst_data_valid = 1'b1; ctl_left--;
      end else begin
        mc.rd_burst_finish = 1'b1; ctl_busy = 1'b0;
      end
    end
  end

  logic [15:0] wr_at_edge;
  initial forever begin
    @(posedge mem_clk);
    wr_at_edge = wrusedw;
  end

  // Monitor: every cycle, check new bursts against the model and held bursts for stability.
  bit            prev_req, prev_aclr;
  logic [AB-1:0] held_addr;
  logic [BB-1:0] held_len;
  initial begin
    prev_req = 1'b0; prev_aclr = 1'b0; held_addr = '0; held_len = '0;
    forever begin
      @(negedge mem_clk);
      if (rst) begin
        prev_req = 1'b0; prev_aclr = 1'b0;
      end else begin
        if (mc.rd_burst_req && !prev_req) begin
          obs_addr.push_back(mc.rd_burst_addr);
          obs_len.push_back(int'(mc.rd_burst_len));
          chk("burst_fifo_headroom", 64'(wr_at_edge < 16'(FD - BS)), 64'(1));
          chk("burst_pending", 64'(exp_addr_q.size() != 0), 64'(1));
          if (exp_addr_q.size() != 0) begin
            chk("burst_addr", 64'(mc.rd_burst_addr), 64'(exp_addr_q.pop_front()));
            chk("burst_len", 64'(mc.rd_burst_len), 64'(exp_len_q.pop_front()));
          end
          held_addr = mc.rd_burst_addr;
          held_len  = mc.rd_burst_len;
        end else if (mc.rd_burst_req) begin
          chk("burst_addr_stable", 64'(mc.rd_burst_addr), 64'(held_addr));
          chk("burst_len_stable", 64'(mc.rd_burst_len), 64'(held_len));
        end
        if (mc.rd_burst_req) chk("busy_in_burst", 64'(busy), 64'(1));
        if (read_finish) begin
          chk("finish_frame_done", 64'(frame_active && exp_addr_q.size() == 0), 64'(1));
          frame_active = 1'b0;
          finish_cnt++;
        end
        if (fifo_aclr && !prev_aclr) aclr_rises++;
        prev_req  = mc.rd_burst_req;
        prev_aclr = fifo_aclr;
      end
    end
  end

  task automatic start_frame(input int idx, input int len);
    bit got;
    @(negedge mem_clk);
    read_addr_index = IB'(idx);
    read_len        = AB'(len);
    repeat (3) @(negedge mem_clk);
    model_load(idx, len);
    n_req++;
    read_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge mem_clk);
      got = read_req_ack;
    end
    chk("ack_seen", 64'(read_req_ack), 64'(1));
    read_req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 2000 && finish_cnt < target; i++) @(negedge mem_clk);
    chk("frame_finished", 64'(finish_cnt), 64'(target));
    repeat (2) @(negedge mem_clk);
    chk("idle_after_frame", 64'(busy), 64'(0));
  endtask

  task automatic wait_bursts(input int n);
    for (int i = 0; i < 400 && obs_addr.size() < n; i++) @(negedge mem_clk);
    chk("burst_started", 64'(obs_addr.size()), 64'(n));
  endtask

  task automatic chk_burst(input string tag, input int k, input logic [AB-1:0] a, input int l);
    chk({tag, "_addr"}, 64'(obs_addr[k]), 64'(a));
    chk({tag, "_len"}, 64'(obs_len[k]), 64'(l));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req"}, 64'(mc.rd_burst_req), 64'(0));
    chk({tag, "_len"}, 64'(mc.rd_burst_len), 64'(0));
    chk({tag, "_addr"}, 64'(mc.rd_burst_addr), 64'(0));
    chk({tag, "_ack"}, 64'(read_req_ack), 64'(0));
    chk({tag, "_finish"}, 64'(read_finish), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_aclr"}, 64'(fifo_aclr), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int k;
  initial begin
    rst = 1'b1; read_req = 1'b0; read_addr_index = '0; read_len = '0; wrusedw = '0;
    read_addr_bus = {BASE2, BASE1, BASE0};
    repeat (3) @(negedge mem_clk);
    rst = 1'b0;
    @(negedge mem_clk);
    chk_outputs_zero("reset");

    // T1: two full bursts from buffer 1.
    k = obs_addr.size();
    start_frame(1, 256);
    wait_done(1);
    chk_burst("t1_b0", k, 23'h001000, 128);
    chk_burst("t1_b1", k + 1, 23'h001080, 128);

    // T2: short final burst.
    k = obs_addr.size();
    start_frame(0, 300);
    wait_done(2);
    chk_burst("t2_b2", k + 2, 23'h000300, 44);

    // Address wraps modulo 2**ADDR_BITS.
    k = obs_addr.size();
    start_frame(2, 200);
    wait_done(3);
    chk_burst("wrap_b0", k, 23'h7FFFC0, 128);
    chk_burst("wrap_b1", k + 1, 23'h000040, 72);

    // T3: no request while the FIFO lacks headroom; request one cycle after it frees up.
    k = obs_addr.size();
    wrusedw = 16'd400;
    start_frame(1, 100);
    repeat (30) @(negedge mem_clk);
    chk("t3_held_off", 64'(mc.rd_burst_req), 64'(0));
    chk("t3_no_burst", 64'(obs_addr.size()), 64'(k));
    wrusedw = 16'd383;
    @(negedge mem_clk);
    chk("t3_req_next", 64'(mc.rd_burst_req), 64'(1));
    wrusedw = 16'd0;
    wait_done(4);
    chk_burst("t3_b0", k, 23'h001000, 100);

    // T5: zero-length frame, then an out-of-range index selecting buffer 0.
    k = obs_addr.size();
    start_frame(3, 0);
    wait_done(5);
    chk("t5_no_bursts", 64'(obs_addr.size()), 64'(k));
    start_frame(3, 130);
    wait_done(6);
    chk_burst("t5_b0", k, 23'h000200, 128);
    chk_burst("t5_b1", k + 1, 23'h000280, 2);

    // T4: new frame requested mid-burst; the old frame never finishes.
    k = obs_addr.size();
    start_frame(0, 300);
    wait_bursts(k + 1);
    repeat (5) @(negedge mem_clk);
    start_frame(1, 140);
    wait_done(7);
    chk_burst("t4_old", k, 23'h000200, 128);
    chk_burst("t4_new_b0", k + 1, 23'h001000, 128);
    chk_burst("t4_new_b1", k + 2, 23'h001080, 12);

    // T6: reset mid-burst clears outputs at once; next frame runs cleanly.
    k = obs_addr.size();
    start_frame(1, 256);
    wait_bursts(k + 1);
    repeat (10) @(negedge mem_clk);
    #2 rst = 1'b1;
    #1 chk_outputs_zero("t6_rst");
    exp_addr_q.delete();
    exp_len_q.delete();
    frame_active = 1'b0;
    repeat (2) @(negedge mem_clk);
    rst = 1'b0;
    k = obs_addr.size();
    start_frame(2, 10);
    wait_done(8);
    chk_burst("t6_clean", k, 23'h7FFFC0, 10);

    chk("aclr_per_request", 64'(aclr_rises), 64'(n_req));
    chk("model_drained", 64'(exp_addr_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
